// File: rtl/seg7_ctrl.sv
// seg7_ctrl: register-mapped 8-digit seven-segment pattern generator with debug override and blink
module seg7_ctrl #(
   parameter int BLINK_DIV = 50_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        bus_req,
   input  logic        bus_we,
   input  logic [2:0]  bus_addr,
   input  logic [31:0] bus_wdata,
   output logic [31:0] bus_rdata,
   output logic        bus_ack,
   input  logic        dbg_en,
   input  logic [31:0] dbg_value,
   output logic [63:0] numbers
);
   localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
   typedef enum logic {IDLE, ACK} state_t;
   state_t state, state_nxt;
   logic [31:0] value, raw_lo, raw_hi, ctrl, rd_mux;
   logic [CW-1:0] blink_cnt;
   logic blink_phase, wr, rd;
   logic [63:0] raw, numbers_nxt;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'h3F;
         4'h1: hex7 = 7'h06;
         4'h2: hex7 = 7'h5B;
         4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;
         4'h5: hex7 = 7'h6D;
         4'h6: hex7 = 7'h7D;
         4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;
         4'h9: hex7 = 7'h6F;
         4'hA: hex7 = 7'h77;
         4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;
         4'hD: hex7 = 7'h5E;
         4'hE: hex7 = 7'h79;
         default: hex7 = 7'h71;
      endcase
   endfunction

   always_comb begin
      state_nxt = IDLE;
      wr = 1'b0;
      rd = 1'b0;
      if (state == IDLE && bus_req) begin
         state_nxt = ACK;
         wr = bus_we;
         rd = !bus_we;
      end
   end

   always_comb begin
      rd_mux = 32'h0;
      case (bus_addr)
         3'd0: rd_mux = value;
         3'd1: rd_mux = raw_lo;
         3'd2: rd_mux = raw_hi;
         3'd3: rd_mux = ctrl;
         3'd4: rd_mux = {30'b0, blink_phase, dbg_en};
         default: rd_mux = 32'h0;
      endcase
   end

   assign raw = {raw_hi, raw_lo};
   assign bus_ack = (state == ACK);

   // Debug override wins, then blank, then blink-off phase, then raw, then hex with dp.
   for (genvar i = 0; i < 8; i++) begin : g_digit
      assign numbers_nxt[8*i +: 8] =
         dbg_en                          ? {1'b0, hex7(dbg_value[4*i +: 4])} :
         ctrl[16+i]                      ? 8'h00 :
         (ctrl[24+i] && blink_phase)     ? 8'h00 :
         ctrl[i]                         ? raw[8*i +: 8] :
                                           {ctrl[8+i], hex7(value[4*i +: 4])};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         value       <= '0;
         raw_lo      <= '0;
         raw_hi      <= '0;
         ctrl        <= '0;
         bus_rdata   <= '0;
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
         numbers     <= '0;
      end else begin
         state   <= state_nxt;
         numbers <= numbers_nxt;
         if (rd) bus_rdata <= rd_mux;
         if (wr && bus_addr == 3'd0) value  <= bus_wdata;
         if (wr && bus_addr == 3'd1) raw_lo <= bus_wdata;
         if (wr && bus_addr == 3'd2) raw_hi <= bus_wdata;
         if (wr && bus_addr == 3'd3) ctrl   <= bus_wdata;
         if (blink_cnt == CW'(BLINK_DIV - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= !blink_phase;
         end else begin
            blink_cnt <= blink_cnt + CW'(1);
         end
      end
   end
endmodule

// File: tb/tb_seg7_ctrl.sv
// tb_seg7_ctrl: directed bench for seg7_ctrl with a small blink-phase reference model
module tb_seg7_ctrl;
   localparam int DIV = 4;
   localparam logic [63:0] ALL0 = 64'h3F3F3F3F3F3F3F3F;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        bus_req = 1'b0, bus_we = 1'b0;
   logic [2:0]  bus_addr = '0;
   logic [31:0] bus_wdata = '0, bus_rdata, rd;
   logic        bus_ack;
   logic        dbg_en = 1'b0;
   logic [31:0] dbg_value = '0;
   logic [63:0] numbers;
   int n_chk = 0, n_fail = 0;
   int m_cnt;
   logic m_phase, m_prev;

   seg7_ctrl #(.BLINK_DIV(DIV)) dut (
      .clk(clk), .rst_n(rst_n), .bus_req(bus_req), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
      .bus_ack(bus_ack), .dbg_en(dbg_en), .dbg_value(dbg_value), .numbers(numbers)
   );

   always #5 clk = ~clk;

   // m_prev is the phase the DUT used when it last registered numbers / read data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt <= 0;
         m_phase <= 1'b0;
         m_prev <= 1'b0;
      end else begin
         m_prev <= m_phase;
         m_cnt <= (m_cnt == DIV - 1) ? 0 : m_cnt + 1;
         if (m_cnt == DIV - 1) m_phase <= !m_phase;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_xfer(input logic we, input logic [2:0] a, input logic [31:0] d,
                           output logic [31:0] r);
      int n = 0;
      bus_req = 1'b1; bus_we = we; bus_addr = a; bus_wdata = d;
      do begin
         tick(1);
         n++;
      end while (!bus_ack && n < 8);
      check("ack", {63'b0, bus_ack}, 64'h1);
      r = bus_rdata;
      bus_req = 1'b0;
   endtask

   initial begin
      #2;
      check("rst_numbers", numbers, 64'h0);
      check("rst_ack", {63'b0, bus_ack}, 64'h0);
      check("rst_rdata", {32'b0, bus_rdata}, 64'h0);
      @(negedge clk) rst_n = 1'b1;
      tick(2);
      check("idle_numbers", numbers, ALL0);
      check("idle_ack", {63'b0, bus_ack}, 64'h0);
      bus_xfer(1'b0, 3'd4, '0, rd);
      check("status_reset", {32'b0, rd}, {62'b0, m_prev, 1'b0});

      bus_xfer(1'b1, 3'd0, 32'h89ABCDEF, rd);
      tick(1);
      check("hex_all", numbers, 64'h7F6F777C395E7971);
      bus_xfer(1'b0, 3'd0, '0, rd);
      check("rd_value", {32'b0, rd}, 64'h89ABCDEF);
      bus_req = 1'b1; bus_we = 1'b0; bus_addr = 3'd0;
      for (int k = 0; k < 6; k++) begin
         tick(1);
         check("held_ack", {63'b0, bus_ack}, {63'b0, k[0]});
      end
      bus_req = 1'b0;
      tick(1);

      bus_xfer(1'b1, 3'd0, 32'h0, rd);
      bus_xfer(1'b1, 3'd1, 32'h000000AA, rd);
      bus_xfer(1'b1, 3'd3, 32'h00020101, rd);
      tick(1);
      check("raw_blank", numbers, 64'h3F3F3F3F3F3F00AA);
      bus_xfer(1'b0, 3'd3, '0, rd);
      check("rd_ctrl", {32'b0, rd}, 64'h00020101);

      bus_xfer(1'b1, 3'd3, 32'h80000000, rd);
      tick(1);
      for (int k = 0; k < 12; k++) begin
         check("blink", numbers, m_prev ? 64'h003F3F3F3F3F3F3F : ALL0);
         tick(1);
      end
      bus_xfer(1'b0, 3'd4, '0, rd);
      check("status_blink", {32'b0, rd}, {62'b0, m_prev, 1'b0});
      tick(1);
      bus_xfer(1'b0, 3'd4, '0, rd);
      check("status_blink2", {32'b0, rd}, {62'b0, m_prev, 1'b0});

      bus_xfer(1'b1, 3'd3, 32'h00FF0000, rd);
      tick(1);
      check("blank_all", numbers, 64'h0);
      dbg_en = 1'b1; dbg_value = 32'h00000001;
      tick(1);
      check("dbg_on", numbers, 64'h3F3F3F3F3F3F3F06);
      bus_xfer(1'b1, 3'd0, 32'h12345678, rd);
      tick(1);
      check("dbg_hold", numbers, 64'h3F3F3F3F3F3F3F06);
      bus_xfer(1'b0, 3'd4, '0, rd);
      check("status_dbg", {32'b0, rd}, {62'b0, m_prev, 1'b1});
      dbg_en = 1'b0;
      tick(1);
      check("dbg_off", numbers, 64'h0);
      bus_xfer(1'b1, 3'd3, 32'h0, rd);
      tick(1);
      check("value_dbg_write", numbers, 64'h065B4F666D7D077F);

      bus_req = 1'b1; bus_we = 1'b1; bus_addr = 3'd0; bus_wdata = 32'hCAFEF00D;
      tick(1);
      check("pre_rst_ack", {63'b0, bus_ack}, 64'h1);
      rst_n = 1'b0;
      #1;
      check("async_ack", {63'b0, bus_ack}, 64'h0);
      check("async_numbers", numbers, 64'h0);
      bus_req = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      bus_xfer(1'b1, 3'd6, 32'hDEADBEEF, rd);
      bus_xfer(1'b0, 3'd6, '0, rd);
      check("rd_unmapped", {32'b0, rd}, 64'h0);
      bus_xfer(1'b0, 3'd0, '0, rd);
      check("rd_value_rst", {32'b0, rd}, 64'h0);
      tick(1);
      check("numbers_after_rst", numbers, ALL0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
